// File: rtl/pc_branch_unit.sv
// Fetch-stage PC and IF/ID PC registers with PC-relative branch target generation and wrong-path squash.
// Optional macro PC_BR_REG_EN adds a register-indirect branch target (br_reg, br_is_reg).
module pc_branch_unit #(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter bit          DELAY_SLOT = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [63:0] br_offset,
`ifdef PC_BR_REG_EN
  input  logic [63:0] br_reg,
  input  logic        br_is_reg,
`endif
  output logic [63:0] if_pc,
  output logic [63:0] id_pc,
  output logic [63:0] br_target,
  output logic        if_flush
);

  typedef enum logic {
    RUN      = 1'b0,
    REDIRECT = 1'b1
  } state_t;

  state_t      state_q;
  logic [63:0] if_pc_q;
  logic [63:0] id_pc_q;
  logic        if_flush_q;

  logic [63:0] target_d;
  logic [63:0] if_pc_d;
  logic        take_branch;

  // Offset bits [63:62] fall off the shift; the extender keeps them equal to the sign.
  always_comb begin
    // NOTE: default assignment first so every path drives target_d and no latch is inferred.
    target_d = id_pc_q + {br_offset[61:0], 2'b00};
`ifdef PC_BR_REG_EN
    if (br_is_reg) begin
      target_d = {br_reg[63:2], 2'b00};
    end
`endif
  end

  // The instruction in ID during REDIRECT is the squashed wrong-path one, so it cannot branch.
  assign take_branch = br_taken && (state_q == RUN);

  always_comb begin
    if_pc_d = if_pc_q + 64'd4;
    if (take_branch) begin
      if_pc_d = target_d;
    end
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= RUN;
      if_pc_q    <= RESET_PC;
      id_pc_q    <= RESET_PC;
      if_flush_q <= 1'b0;
    end else if (!stall) begin
      id_pc_q <= if_pc_q;
      if_pc_q <= if_pc_d;
      case (state_q)
        RUN: begin
          if (take_branch && !DELAY_SLOT) begin
            state_q    <= REDIRECT;
            if_flush_q <= 1'b1;
          end else begin
            state_q    <= RUN;
            if_flush_q <= 1'b0;
          end
        end
        REDIRECT: begin
          state_q    <= RUN;
          if_flush_q <= 1'b0;
        end
        default: begin
          state_q    <= RUN;
          if_flush_q <= 1'b0;
        end
      endcase
    end
  end

  assign if_pc     = if_pc_q;
  assign id_pc     = id_pc_q;
  assign br_target = target_d;
  assign if_flush  = if_flush_q;

endmodule
